// File: rtl/team_autopilot_buttons_pkg.sv
// Shared game definitions for the autopilot button driver.
// Holds the autopilot FSM state type, the legal player range and the
// active-low button encoding used on the vu/vd pins.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_PRESS_UP,
        ST_PRESS_DOWN
    } autopilot_state_t;

    localparam int PLAYER_MIN_POS = 62;
    localparam int PLAYER_MAX_POS = 485;

    localparam logic BTN_PRESSED  = 1'b0;
    localparam logic BTN_RELEASED = 1'b1;

    // Width of the sample and hold/gap timers; covers SAMPLE_CYCLES comfortably.
    localparam int TIMER_W = 16;

endpackage

// File: rtl/team_autopilot_buttons_if.sv
// Button interface between the autopilot (master) and the team controller /
// board mux (slave).
//   enable      autopilot active; 0 forces release
//   target_pos  desired vertical position
//   cur_pos     player position fed back from the controller
//   vu_button   up button, active-low
//   vd_button   down button, active-low
//   active      high while a press is asserted
interface team_autopilot_buttons_if #(
    parameter int POS_W = 10
);
    logic             enable;
    logic [POS_W-1:0] target_pos;
    logic [POS_W-1:0] cur_pos;
    logic             vu_button;
    logic             vd_button;
    logic             active;

    modport master (
        input  enable,
        input  target_pos,
        input  cur_pos,
        output vu_button,
        output vd_button,
        output active
    );

    modport slave (
        output enable,
        output target_pos,
        output cur_pos,
        input  vu_button,
        input  vd_button,
        input  active
    );
endinterface

// File: rtl/team_autopilot_buttons_timer.sv
// autopilot_timer: clearable up-counter with a terminal-count flag.
//   clk, rst_n  clock and asynchronous active-low reset
//   clear       synchronous return to zero (wins over en)
//   en          count up by one
//   limit       terminal value
//   tc          count == limit
module autopilot_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);
    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == limit);
endmodule

// File: rtl/team_autopilot_buttons.sv
// team_autopilot_buttons: computer player for one team's vertical axis.
// Compares the player position with a clamped target and drives synthetic
// active-low up/down presses so the player tracks the target.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    master side of team_autopilot_buttons_if
//          (enable, target_pos, cur_pos in; vu_button, vd_button, active out)
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_IDLE       | both released, sample timer running toward next decision
// ST_GAP        | both released for GAP_CYCLES before a new/reversed press
// ST_PRESS_UP   | vu held low; re-evaluated every cycle once hold is met
// ST_PRESS_DOWN | vd held low; re-evaluated every cycle once hold is met
module team_autopilot_buttons
    import game_pkg::*;
#(
    parameter int POS_W         = 10,
    parameter int MIN_POS       = PLAYER_MIN_POS,
    parameter int MAX_POS       = PLAYER_MAX_POS,
    parameter int DEADBAND      = 4,
    parameter int SAMPLE_CYCLES = 1000,
    parameter int HOLD_CYCLES   = 200,
    parameter int GAP_CYCLES    = 4
) (
    input  logic clk,
    input  logic rst_n,
    team_autopilot_buttons_if.master bus
);
    localparam logic [TIMER_W-1:0]   SAMPLE_LIM = TIMER_W'(SAMPLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0]   HOLD_LIM   = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0]   GAP_LIM    = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [POS_W-1:0]     MIN_P      = POS_W'(MIN_POS);
    localparam logic [POS_W-1:0]     MAX_P      = POS_W'(MAX_POS);
    localparam logic signed [POS_W:0] DB        = (POS_W+1)'(DEADBAND);

    autopilot_state_t   state, state_next;
    logic               pend_up, pend_up_next;
    logic [POS_W-1:0]   tgt_c;
    logic signed [POS_W:0] err;
    logic               err_lo, err_hi;
    logic               smp_tc, smp_clear, smp_en;
    logic               hg_tc, hg_clear, hg_en;
    logic [TIMER_W-1:0] hg_limit;
    logic               vu_q, vd_q, act_q;

    always_comb begin
        tgt_c = bus.target_pos;
        if (bus.target_pos < MIN_P) tgt_c = MIN_P;
        if (bus.target_pos > MAX_P) tgt_c = MAX_P;
    end

    // Negative error means the target is above the player (smaller y): press up.
    assign err    = $signed({1'b0, tgt_c}) - $signed({1'b0, bus.cur_pos});
    assign err_lo = (err < -DB);
    assign err_hi = (err > DB);

    always_comb begin
        state_next   = state;
        pend_up_next = pend_up;
        if (!bus.enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (smp_tc) begin
                        if (err_lo) begin
                            state_next   = ST_GAP;
                            pend_up_next = 1'b1;
                        end else if (err_hi) begin
                            state_next   = ST_GAP;
                            pend_up_next = 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    if (hg_tc) state_next = pend_up ? ST_PRESS_UP : ST_PRESS_DOWN;
                end
                ST_PRESS_UP: begin
                    if (hg_tc) begin
                        if (err_hi) begin
                            state_next   = ST_GAP;
                            pend_up_next = 1'b0;
                        end else if (!err_lo || bus.cur_pos <= MIN_P) begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                ST_PRESS_DOWN: begin
                    if (hg_tc) begin
                        if (err_lo) begin
                            state_next   = ST_GAP;
                            pend_up_next = 1'b1;
                        end else if (!err_hi || bus.cur_pos >= MAX_P) begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Sample timer restarts on every terminal count and is held at zero
    // outside IDLE, so each return to IDLE starts a full interval.
    assign smp_en    = (state == ST_IDLE) && bus.enable;
    assign smp_clear = !bus.enable || (state != ST_IDLE) || smp_tc;

    // Hold/gap timer is cleared on every state change; it saturates at its
    // limit so a press past the minimum hold keeps hg_tc asserted.
    assign hg_limit = (state == ST_GAP) ? GAP_LIM : HOLD_LIM;
    assign hg_en    = (state != ST_IDLE) && !hg_tc;
    assign hg_clear = !bus.enable || (state_next != state);

    autopilot_timer #(.W(TIMER_W)) u_sample_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (smp_clear),
        .en    (smp_en),
        .limit (SAMPLE_LIM),
        .tc    (smp_tc)
    );

    autopilot_timer #(.W(TIMER_W)) u_hold_gap_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (hg_clear),
        .en    (hg_en),
        .limit (hg_limit),
        .tc    (hg_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pend_up <= 1'b0;
        end else begin
            state   <= state_next;
            pend_up <= pend_up_next;
        end
    end

    // Pins are decoded from the next state so they change together with it;
    // at most one press state exists, so both buttons can never be low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vu_q  <= BTN_RELEASED;
            vd_q  <= BTN_RELEASED;
            act_q <= 1'b0;
        end else begin
            vu_q  <= (state_next == ST_PRESS_UP)   ? BTN_PRESSED : BTN_RELEASED;
            vd_q  <= (state_next == ST_PRESS_DOWN) ? BTN_PRESSED : BTN_RELEASED;
            act_q <= (state_next == ST_PRESS_UP) || (state_next == ST_PRESS_DOWN);
        end
    end

    assign bus.vu_button = vu_q;
    assign bus.vd_button = vd_q;
    assign bus.active    = act_q;
endmodule

// File: tb/tb_team_autopilot_buttons.sv
// Self-checking bench for team_autopilot_buttons.
module tb_team_autopilot_buttons;
    import game_pkg::*;

    localparam int POS_W  = 10;
    localparam int SAMPLE = 1000;
    localparam int HOLD   = 200;
    localparam int GAP    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    team_autopilot_buttons_if #(.POS_W(POS_W)) bus_if ();

    team_autopilot_buttons #(
        .POS_W(POS_W), .MIN_POS(62), .MAX_POS(485), .DEADBAND(4),
        .SAMPLE_CYCLES(SAMPLE), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        string name;
        logic  vu;
        logic  vd;
    } exp_t;

    typedef struct {
        string            name;
        logic [POS_W-1:0] tgt;
        logic [POS_W-1:0] cur;
        logic             vu;
        logic             vd;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];

    int n_cmp     = 0;
    int n_bad     = 0;
    int both_low  = 0;
    int step_cnt  = 0;
    logic model_on = 1'b0;

    // One clock, then a simple controller model: the player moves one step
    // per 99 cycles of continuous press (up = smaller y).
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus_if.vu_button == 1'b0 && bus_if.vd_button == 1'b0) both_low++;
        if (model_on) begin
            if (!bus_if.vu_button || !bus_if.vd_button) begin
                step_cnt++;
                if (step_cnt == 99) begin
                    step_cnt = 0;
                    if (!bus_if.vu_button) bus_if.cur_pos = bus_if.cur_pos - 10'd1;
                    else                   bus_if.cur_pos = bus_if.cur_pos + 10'd1;
                end
            end else begin
                step_cnt = 0;
            end
        end
    endtask

    task automatic push(input string n, input logic vu, input logic vd);
        exp_t e;
        e.name = n;
        e.vu   = vu;
        e.vd   = vd;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        logic ea;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: got no expectation");
            return;
        end
        e  = sb.pop_front();
        ea = ~(e.vu & e.vd);
        if (bus_if.vu_button !== e.vu || bus_if.vd_button !== e.vd || bus_if.active !== ea) begin
            n_bad++;
            $display("FAIL %s: got vu=%b vd=%b active=%b, want vu=%b vd=%b active=%b",
                     e.name, bus_if.vu_button, bus_if.vd_button, bus_if.active, e.vu, e.vd, ea);
        end
    endtask

    task automatic check_now(input string n, input logic vu, input logic vd);
        push(n, vu, vd);
        check_pop();
    endtask

    task automatic check_val(input string n, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", n, got, want);
        end
    endtask

    // Forces IDLE with one disabled cycle, then re-enables with new inputs.
    task automatic restart(input logic [POS_W-1:0] t, input logic [POS_W-1:0] c);
        model_on       = 1'b0;
        step_cnt       = 0;
        bus_if.enable  = 1'b0;
        tick();
        bus_if.target_pos = t;
        bus_if.cur_pos    = c;
        bus_if.enable     = 1'b1;
    endtask

    // After restart: released through the decision and gap, press on cycle 1004.
    task automatic expect_decision(input string n, input logic vu, input logic vd);
        push({n, "_pre"}, 1'b1, 1'b1);
        push(n, vu, vd);
        repeat (SAMPLE + GAP - 1) tick();
        check_pop();
        tick();
        check_pop();
    endtask

    initial begin
        int cnt;
        int reach;
        int rel;

        vecs[0]  = '{"on_target",      10'd300,  10'd300, 1'b1, 1'b1};
        vecs[1]  = '{"up_far",         10'd200,  10'd300, 1'b0, 1'b1};
        vecs[2]  = '{"down_far",       10'd400,  10'd300, 1'b1, 1'b0};
        vecs[3]  = '{"db_edge_hi",     10'd304,  10'd300, 1'b1, 1'b1};
        vecs[4]  = '{"db_out_hi",      10'd305,  10'd300, 1'b1, 1'b0};
        vecs[5]  = '{"db_edge_lo",     10'd296,  10'd300, 1'b1, 1'b1};
        vecs[6]  = '{"db_out_lo",      10'd295,  10'd300, 1'b0, 1'b1};
        vecs[7]  = '{"clamp_min_in",   10'd40,   10'd63,  1'b1, 1'b1};
        vecs[8]  = '{"clamp_min_out",  10'd40,   10'd70,  1'b0, 1'b1};
        vecs[9]  = '{"clamp_max_in",   10'd600,  10'd482, 1'b1, 1'b1};
        vecs[10] = '{"clamp_max_out",  10'd600,  10'd480, 1'b1, 1'b0};
        vecs[11] = '{"clamp_min_edge", 10'd0,    10'd66,  1'b1, 1'b1};

        // Test 1: reset state, then five idle intervals on target.
        bus_if.enable     = 1'b1;
        bus_if.target_pos = 10'd300;
        bus_if.cur_pos    = 10'd300;
        #12;
        check_now("reset", 1'b1, 1'b1);
        #5 rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5 * SAMPLE; i++) begin
            tick();
            if (bus_if.vu_button == 1'b0 || bus_if.vd_button == 1'b0) cnt++;
        end
        check_val("idle_5_intervals_press_cycles", cnt, 0);

        // Decision table: direction, deadband edges and target clamping.
        for (int i = 0; i < 12; i++) begin
            restart(vecs[i].tgt, vecs[i].cur);
            expect_decision(vecs[i].name, vecs[i].vu, vecs[i].vd);
        end

        // Test 2: long up press tracked down to the deadband edge.
        restart(10'd200, 10'd300);
        model_on = 1'b1;
        expect_decision("t2_press", 1'b0, 1'b1);
        reach = -1;
        rel   = -1;
        for (int k = 1; k <= 12000; k++) begin
            tick();
            if (bus_if.vu_button == 1'b1) begin
                rel = k;
                break;
            end
            if (reach < 0 && bus_if.cur_pos <= 10'd204) reach = k;
        end
        check_val("t2_release_cur", int'(bus_if.cur_pos), 204);
        check_val("t2_release_latency", rel - reach, 1);
        check_now("t2_released", 1'b1, 1'b1);

        // Test 3: clamped target within deadband, then an up press to 66.
        restart(10'd40, 10'd63);
        repeat (SAMPLE + GAP) tick();
        check_now("t3_clamp_nopress", 1'b1, 1'b1);
        bus_if.cur_pos = 10'd70;
        model_on = 1'b1;
        rel = -1;
        for (int k = 1; k <= 1100; k++) begin
            tick();
            if (bus_if.vu_button == 1'b0) begin
                rel = k;
                break;
            end
        end
        check_now("t3_press", 1'b0, 1'b1);
        reach = -1;
        rel   = -1;
        for (int k = 1; k <= 1000; k++) begin
            tick();
            if (bus_if.vu_button == 1'b1) begin
                rel = k;
                break;
            end
            if (reach < 0 && bus_if.cur_pos <= 10'd66) reach = k;
        end
        check_val("t3_release_cur", int'(bus_if.cur_pos), 66);
        check_val("t3_release_latency", rel - reach, 1);

        // Minimum hold: target met right after press starts, held 200 cycles.
        restart(10'd300, 10'd290);
        expect_decision("hold_press", 1'b1, 1'b0);
        bus_if.cur_pos = 10'd300;
        cnt = 0;
        for (int k = 2; k <= HOLD; k++) begin
            tick();
            if (bus_if.vd_button != 1'b0) cnt++;
        end
        check_val("hold_min_early_release_cycles", cnt, 0);
        tick();
        check_now("hold_release", 1'b1, 1'b1);

        // Test 4: overshoot during a down press reverses through GAP.
        restart(10'd300, 10'd200);
        model_on = 1'b1;
        expect_decision("t4_press", 1'b1, 1'b0);
        repeat (249) tick();
        model_on = 1'b0;
        bus_if.cur_pos = 10'd320;
        tick();
        check_now("t4_release", 1'b1, 1'b1);
        for (int k = 0; k < GAP - 1; k++) begin
            tick();
            check_now("t4_gap", 1'b1, 1'b1);
        end
        tick();
        check_now("t4_reverse", 1'b0, 1'b1);

        // Test 5: enable dropped mid-press, then a fresh sample interval.
        restart(10'd400, 10'd300);
        expect_decision("t5_press", 1'b1, 1'b0);
        repeat (49) tick();
        bus_if.enable = 1'b0;
        tick();
        check_now("t5_disable", 1'b1, 1'b1);
        bus_if.enable = 1'b1;
        expect_decision("t5_fresh_press", 1'b1, 1'b0);

        // Enable dropped mid-GAP: gap must not resume after re-enable.
        restart(10'd400, 10'd300);
        repeat (SAMPLE + 1) tick();
        bus_if.enable = 1'b0;
        tick();
        check_now("t5b_gap_disable", 1'b1, 1'b1);
        bus_if.enable = 1'b1;
        expect_decision("t5b_fresh_press", 1'b1, 1'b0);

        // Test 6: asynchronous reset mid-press.
        restart(10'd400, 10'd300);
        expect_decision("t6_press", 1'b1, 1'b0);
        repeat (10) tick();
        #3 rst_n = 1'b0;
        #1 check_now("t6_async_release", 1'b1, 1'b1);
        #2 rst_n = 1'b1;
        expect_decision("t6_resume", 1'b1, 1'b0);

        check_val("both_low_cycles", both_low, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
